vga_mode_sequencer: RTL
=======================

VGA_MODE_SEQUENCER -- requirements
Module: vga_mode_sequencer

Interface
REQ-001 Parameter C_MODES, default 4: number of selectable video modes, legal range 2..16.
REQ-002 Parameter C_INIT_MODE, default 0: mode index selected after reset.
REQ-003 Parameter C_DEBOUNCE_BITS, default 16: a button level is accepted after it is stable for 2^N-1 clk_25mhz cycles.
REQ-004 Parameter C_PLL_RST_CYCLES, default 16: length of the pll_rst pulse, in cycles.
REQ-005 Parameter C_LOCK_TIMEOUT_BITS, default 20: WAIT_LOCK times out after 2^N-1 cycles.
REQ-006 Parameter C_SETTLE_FRAMES, default 2: number of muted frames after lock before video is released.
REQ-007 Port clk_25mhz, input, 1 bit: single clock; all logic is on its rising edge.
REQ-008 Port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-009 Port btn_next, input, 1 bit: raw asynchronous button that selects the next mode.
REQ-010 Port btn_prev, input, 1 bit: raw asynchronous button that selects the previous mode.
REQ-011 Port vga_vsync, input, 1 bit: vsync from the pixel-clock domain; asynchronous to clk_25mhz.
REQ-012 Port pll_locked, input, 1 bit: PLL lock indicator; asynchronous.
REQ-013 Port mode_sel, output, 4 bits: active mode index, range 0..C_MODES-1.
REQ-014 Port pll_rst, output, 1 bit: active-high PLL reset.
REQ-015 Port video_mute, output, 1 bit: forces blanking downstream.
REQ-016 Port busy, output, 1 bit: high in every state except RUN.
REQ-017 Port lock_err, output, 1 bit: sticky flag set by a lock timeout.

Function
REQ-018 btn_next, btn_prev, vga_vsync and pll_locked SHALL each pass through a 2-flop synchronizer; input-to-internal latency is 2 cycles.
REQ-019 Each button debouncer SHALL clear its counter whenever the synchronized level differs from the accepted level.
REQ-020 Each debouncer SHALL copy the synchronized level into the accepted level when its counter reaches 2^C_DEBOUNCE_BITS-1.
REQ-021 A press event SHALL be a 1-cycle pulse on an accepted 0->1 transition.
REQ-022 Press events SHALL be acted on only in RUN; presses in other states are discarded, not queued.
REQ-023 Simultaneous next and prev press events SHALL both be discarded.
REQ-024 target = mode_sel+1 on next and mode_sel-1 on prev; C_MODES-1 wraps to 0 on next and 0 wraps to C_MODES-1 on prev; prev_mode <= mode_sel.
REQ-025 A frame edge SHALL be the rising edge of the synchronized vsync.
REQ-026 FSM states: RUN, WAIT_FRAME, MUTE, PLL_RST, WAIT_LOCK, SETTLE.
REQ-027 RUN: pll_rst=0, video_mute=0, busy=0.
REQ-028 RUN, on a valid press -> WAIT_FRAME.
REQ-029 RUN, on synchronized pll_locked=0 -> PLL_RST with the same mode and video_mute=1.
REQ-030 WAIT_FRAME: busy=1, video_mute=0; on a frame edge -> MUTE, with video_mute=1 from the next cycle.
REQ-031 MUTE: on the next frame edge -> PLL_RST, and mode_sel <= target on the transition cycle.
REQ-032 PLL_RST: pll_rst=1 for exactly C_PLL_RST_CYCLES cycles -> WAIT_LOCK.
REQ-033 WAIT_LOCK: pll_rst=0; synchronized lock=1 -> SETTLE.
REQ-034 WAIT_LOCK, on timeout: lock_err<=1, mode_sel<=prev_mode, target<=prev_mode -> PLL_RST.
REQ-035 A timeout in the fallback mode SHALL retry indefinitely, without stopping.
REQ-036 SETTLE: video_mute=1; count C_SETTLE_FRAMES frame edges -> RUN.
REQ-037 SETTLE, on loss of lock -> PLL_RST with the same mode, and the frame count is cleared.
REQ-038 video_mute SHALL be 1 in MUTE, PLL_RST, WAIT_LOCK and SETTLE.
REQ-039 lock_err SHALL clear only on reset.
REQ-040 All counters SHALL saturate or clear on state exit and never wrap.

Reset
REQ-041 While rst_n=0 at a clock edge: state=PLL_RST with its counter at 0, mode_sel=C_INIT_MODE, pll_rst=1, video_mute=1, busy=1, lock_err=0.
REQ-042 While rst_n=0 at a clock edge: synchronizers=0, accepted levels=0, target=prev_mode=C_INIT_MODE.
REQ-043 Reset asserted in any state SHALL take effect at the next edge.

Verification (C_MODES=4, C_DEBOUNCE_BITS=2, C_PLL_RST_CYCLES=4, C_LOCK_TIMEOUT_BITS=4, C_SETTLE_FRAMES=2)
REQ-044 Release rst_n with lock held 1 -> pll_rst high 4 cycles, then after 2 vsync rising edges: video_mute=0, busy=0, mode_sel=0.
REQ-045 btn_next high 2 cycles -> no change; btn_next high 10 cycles in RUN -> mute after 1st vsync, mode_sel=1 and pll_rst after 2nd, RUN after lock plus 2 frames.
REQ-046 mode_sel=3 plus next -> 0; mode_sel=0 plus prev -> 3.
REQ-047 Switch 1->2 with pll_locked held 0 -> after 15 WAIT_LOCK cycles lock_err=1, mode_sel=1, pll_rst pulses again for 4 cycles.
REQ-048 Press during busy, or next+prev in the same cycle, in RUN -> mode_sel unchanged, state stays put.
REQ-049 rst_n=0 during WAIT_LOCK -> next edge: mode_sel=C_INIT_MODE, pll_rst=1, lock_err=0.

Source files
------------

// File: rtl/vga_mode_sequencer.sv
// vga_mode_sequencer: button-driven video mode stepping with frame-aligned muting,
// PLL reset/relock sequencing and fallback to the previous mode on lock timeout.
module vga_mode_sequencer #(
    parameter int C_MODES             = 4,
    parameter int C_INIT_MODE         = 0,
    parameter int C_DEBOUNCE_BITS     = 16,
    parameter int C_PLL_RST_CYCLES    = 16,
    parameter int C_LOCK_TIMEOUT_BITS = 20,
    parameter int C_SETTLE_FRAMES     = 2
) (
    input  logic       clk_25mhz,
    input  logic       rst_n,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       vga_vsync,
    input  logic       pll_locked,
    output logic [3:0] mode_sel,
    output logic       pll_rst,
    output logic       video_mute,
    output logic       busy,
    output logic       lock_err
);
    localparam int W_PLL = $clog2(C_PLL_RST_CYCLES + 1);
    localparam int W_SET = $clog2(C_SETTLE_FRAMES + 1);
    localparam int W_A   = W_PLL > W_SET ? W_PLL : W_SET;
    localparam int W     = C_LOCK_TIMEOUT_BITS > W_A ? C_LOCK_TIMEOUT_BITS : W_A;
    localparam logic [W-1:0] PLL_LAST  = W'(C_PLL_RST_CYCLES - 1);
    localparam logic [W-1:0] LOCK_LAST = W'((1 << C_LOCK_TIMEOUT_BITS) - 2);
    localparam logic [W-1:0] SET_LAST  = W'(C_SETTLE_FRAMES - 1);
    localparam logic [3:0]   LAST_MODE = 4'(C_MODES - 1);
    localparam logic [3:0]   INIT_MODE = 4'(C_INIT_MODE);
    localparam logic [C_DEBOUNCE_BITS-1:0] DB_MAX = '1;

    typedef enum logic [2:0] {
        S_RUN, S_WAIT_FRAME, S_MUTE, S_PLL_RST, S_WAIT_LOCK, S_SETTLE
    } state_t;

    logic [3:0] w_raw;
    logic [3:0] r_s0, r_s1;
    logic       r_vs_d;
    logic       w_frame, w_lock, w_step;
    logic [C_DEBOUNCE_BITS-1:0] r_db_cnt [2];
    logic [1:0] r_db_acc, r_evt;
    logic [3:0] w_next_mode, w_prev_mode;
    state_t     r_state;
    logic [W-1:0] r_cnt;
    logic [3:0] r_mode, r_target, r_prev;
    logic       r_pll_rst, r_mute, r_busy, r_lock_err;

    // bit order: 0 next, 1 prev, 2 vsync, 3 lock
    assign w_raw   = {pll_locked, vga_vsync, btn_prev, btn_next};
    assign w_frame = r_s1[2] & ~r_vs_d;
    assign w_lock  = r_s1[3];
    assign w_step  = r_evt[0] ^ r_evt[1];
    assign w_next_mode = r_mode == LAST_MODE ? 4'd0 : r_mode + 4'd1;
    assign w_prev_mode = r_mode == 4'd0 ? LAST_MODE : r_mode - 4'd1;

    always_ff @(posedge clk_25mhz) begin
        if (!rst_n) begin
            r_s0   <= '0;
            r_s1   <= '0;
            r_vs_d <= 1'b0;
        end else begin
            r_s0   <= w_raw;
            r_s1   <= r_s0;
            r_vs_d <= r_s1[2];
        end
    end

    // A pending level change must persist unbroken for DB_MAX cycles; any return clears it
    always_ff @(posedge clk_25mhz) begin
        if (!rst_n) begin
            r_db_cnt[0] <= '0;
            r_db_cnt[1] <= '0;
            r_db_acc    <= '0;
            r_evt       <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_evt[i] <= 1'b0;
                if (r_s1[i] == r_db_acc[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_MAX) begin
                    r_db_acc[i] <= r_s1[i];
                    r_db_cnt[i] <= '0;
                    r_evt[i]    <= r_s1[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (!rst_n) begin
            r_state    <= S_PLL_RST;
            r_cnt      <= '0;
            r_mode     <= INIT_MODE;
            r_target   <= INIT_MODE;
            r_prev     <= INIT_MODE;
            r_pll_rst  <= 1'b1;
            r_mute     <= 1'b1;
            r_busy     <= 1'b1;
            r_lock_err <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (!w_lock) begin
                        r_state   <= S_PLL_RST;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b1;
                        r_mute    <= 1'b1;
                        r_busy    <= 1'b1;
                    end else if (w_step) begin
                        r_state  <= S_WAIT_FRAME;
                        r_target <= r_evt[0] ? w_next_mode : w_prev_mode;
                        r_prev   <= r_mode;
                        r_busy   <= 1'b1;
                    end
                end
                S_WAIT_FRAME: begin
                    if (w_frame) begin
                        r_state <= S_MUTE;
                        r_mute  <= 1'b1;
                    end
                end
                S_MUTE: begin
                    if (w_frame) begin
                        r_state   <= S_PLL_RST;
                        r_mode    <= r_target;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b1;
                    end
                end
                S_PLL_RST: begin
                    if (r_cnt == PLL_LAST) begin
                        r_state   <= S_WAIT_LOCK;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (w_lock) begin
                        r_state <= S_SETTLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == LOCK_LAST) begin
                        // fall back to the last working mode; repeats forever if that fails too
                        r_state    <= S_PLL_RST;
                        r_cnt      <= '0;
                        r_pll_rst  <= 1'b1;
                        r_lock_err <= 1'b1;
                        r_mode     <= r_prev;
                        r_target   <= r_prev;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (!w_lock) begin
                        r_state   <= S_PLL_RST;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b1;
                    end else if (w_frame) begin
                        if (r_cnt == SET_LAST) begin
                            r_state <= S_RUN;
                            r_cnt   <= '0;
                            r_mute  <= 1'b0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= S_PLL_RST;
                    r_cnt     <= '0;
                    r_pll_rst <= 1'b1;
                    r_mute    <= 1'b1;
                    r_busy    <= 1'b1;
                end
            endcase
        end
    end

    assign mode_sel   = r_mode;
    assign pll_rst    = r_pll_rst;
    assign video_mute = r_mute;
    assign busy       = r_busy;
    assign lock_err   = r_lock_err;
endmodule
